// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller.
// Holds the FSM state type, the default geometry constants, the
// priority-encoder result struct and helper functions.
package intc_pkg;

    localparam int unsigned NSRC       = 4;
    localparam int unsigned PC_W       = 10;
    localparam int unsigned IDX_W      = $clog2(NSRC);
    localparam int unsigned VEC_STRIDE = 16;
    localparam logic [PC_W-1:0] VEC_BASE = 10'h3C0;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Lowest-index set bit wins (bit 0 = highest priority).
    function automatic prio_t prio_enc(input logic [NSRC-1:0] v);
        prio_t r;
        r = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Handler address for a source index, truncated to the PC width.
    function automatic logic [PC_W-1:0] vec_addr(input logic [IDX_W-1:0] idx);
        return VEC_BASE + PC_W'(32'(idx) * VEC_STRIDE);
    endfunction

endpackage

// File: rtl/intc_sync.sv
// Per-bit two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk, reset (async, active-low)
//   async_i  : raw asynchronous inputs
//   rise_c   : combinational one-cycle pulse on a synchronized 0->1 transition
module intc_sync #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] rise_c
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] prev_q, prev_d;

    // Next-state for the synchronizer chain and edge-history flop.
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/intc_ctrl.sv
// Interrupt controller: latches device requests, arbitrates them by fixed
// priority against the mask and the in-service set, and holds a
// request/vector to the control unit until it is acknowledged.
// Ports:
//   clk, reset (async, active-low)
//   irq_in     : raw device request lines (asynchronous)
//   mask_we    : mask register write strobe; mask_d is the new value
//   irq_ack    : control unit took the vector (pulse)
//   reti       : return-from-interrupt (pulse)
//   irq_req    : request to control unit; irq_vec is valid while it is high
//   pending    : latched, unserviced requests
//   in_service : levels currently being serviced
//   mask       : current mask register
// Build option: define INTC_NEST_EN to allow nesting by priority; otherwise
// only one level is serviced at a time and reti clears all of in_service.
module intc_ctrl
    import intc_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_d,
    input  logic            irq_ack,
    input  logic            reti,
    output logic            irq_req,
    output logic [PC_W-1:0] irq_vec,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] in_service,
    output logic [NSRC-1:0] mask
);

    logic [NSRC-1:0] rise_c;

    state_e          state_q, state_d;
    logic            irq_req_q, irq_req_d;
    logic [PC_W-1:0] irq_vec_q, irq_vec_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] in_service_q, in_service_d;
    logic [NSRC-1:0] mask_reg_q, mask_reg_d;

    logic [NSRC-1:0] above_c;
    logic [NSRC-1:0] reti_clr_c;
    logic [NSRC-1:0] elig_c;
    logic [NSRC-1:0] ack_set_c;
    prio_t           win_c;
    logic            ack_c;

    intc_sync #(.W(NSRC)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(irq_in),
        .rise_c (rise_c)
    );

`ifdef INTC_NEST_EN
    prio_t is_top_c;

    // Only sources strictly above the highest in-service level may interrupt;
    // reti retires just that highest level.
    always_comb begin
        is_top_c   = prio_enc(in_service_q);
        above_c    = '1;
        reti_clr_c = '0;
        if (is_top_c.valid) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                above_c[i] = (i < 32'(is_top_c.idx));
            end
            reti_clr_c[is_top_c.idx] = reti;
        end
    end
`else
    // Single level: nothing is eligible while anything is in service.
    always_comb begin
        above_c    = (|in_service_q) ? '0 : '1;
        reti_clr_c = reti ? '1 : '0;
    end
`endif

    // Arbitration uses the registered mask, so a same-cycle write is not seen.
    always_comb begin
        elig_c = pending_q & mask_reg_q & above_c;
        win_c  = prio_enc(elig_c);
    end

    // Request FSM: request and vector stay frozen in REQ until acknowledged.
    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_vec_d = irq_vec_q;
        idx_d     = idx_q;
        ack_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_c.valid) begin
                    state_d   = REQ;
                    irq_req_d = 1'b1;
                    idx_d     = win_c.idx;
                    irq_vec_d = vec_addr(win_c.idx);
                end
            end
            REQ: begin
                if (irq_ack) begin
                    ack_c     = 1'b1;
                    irq_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                irq_req_d = 1'b0;
            end
        endcase
    end

    // Status registers: a new edge beats the ack clear; reti clears before the ack sets.
    always_comb begin
        ack_set_c        = '0;
        ack_set_c[idx_q] = ack_c;
        pending_d        = (pending_q & ~ack_set_c) | rise_c;
        in_service_d     = (in_service_q & ~reti_clr_c) | ack_set_c;
        mask_reg_d       = mask_we ? mask_d : mask_reg_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            irq_req_q    <= 1'b0;
            irq_vec_q    <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_reg_q   <= '0;
        end else begin
            state_q      <= state_d;
            irq_req_q    <= irq_req_d;
            irq_vec_q    <= irq_vec_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_reg_q   <= mask_reg_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_vec    = irq_vec_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign mask       = mask_reg_q;

endmodule
